// File: rtl/redirect.sv
// Deflection routing core for one node of a 4x2 bufferless mesh.
// All arriving flits are ejected or given an output port in one cycle, and the outputs are registered.
module redirect #(
  parameter int FLIT_W = 11,
  parameter int ID_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   cthulhu,
  input  logic [FLIT_W-1:0] northad,
  input  logic [FLIT_W-1:0] southad,
  input  logic [FLIT_W-1:0] eastad,
  input  logic [FLIT_W-1:0] westad,
  output logic [FLIT_W-1:0] nad,
  output logic [FLIT_W-1:0] sad,
  output logic [FLIT_W-1:0] ead,
  output logic [FLIT_W-1:0] wad,
  output logic [FLIT_W-1:0] buffit,
  output logic              inject
);

  // Both input priority and the fallback port order run N, E, S, W,
  // so one index space serves inputs and outputs.
  localparam logic [1:0] P_N = 2'd0;
  localparam logic [1:0] P_E = 2'd1;
  localparam logic [1:0] P_S = 2'd2;
  localparam logic [1:0] P_W = 2'd3;

  logic [FLIT_W-1:0] in_flit [4];
  logic [FLIT_W-1:0] out_d   [4];
  logic [FLIT_W-1:0] out_q   [4];
  logic [FLIT_W-1:0] buffit_d, buffit_q;
  logic              inject_d, inject_q;
  logic [3:0]        taken;
  logic              ejected;
  logic              has_prod;
  logic [1:0]        prod;
  logic [1:0]        sel;
  logic [ID_W-1:0]   dest;

  function automatic logic [1:0] first_free(input logic [3:0] t);
    first_free = P_N;
    for (int p = 3; p >= 0; p--) begin
      if (!t[p]) first_free = p[1:0];
    end
  endfunction

  // Returns {has_port, port}. No port means the flit is local.
  function automatic logic [2:0] productive(input logic [ID_W-1:0] d,
                                            input logic [ID_W-1:0] id);
    if (d[1:0] > id[1:0])      productive = {1'b1, P_E};
    else if (d[1:0] < id[1:0]) productive = {1'b1, P_W};
    else if (d[2] > id[2])     productive = {1'b1, P_S};
    else if (d[2] < id[2])     productive = {1'b1, P_N};
    else                       productive = {1'b0, P_N};
  endfunction

  always_comb begin
    in_flit[0] = northad;
    in_flit[1] = eastad;
    in_flit[2] = southad;
    in_flit[3] = westad;
    for (int p = 0; p < 4; p++) out_d[p] = '0;
    buffit_d = '0;
    taken    = 4'b0;
    ejected  = 1'b0;
    has_prod = 1'b0;
    prod     = P_N;
    sel      = P_N;
    dest     = '0;
    for (int i = 0; i < 4; i++) begin
      // An X/Z valid bit fails this test, so the slot is treated as empty.
      if (in_flit[i][FLIT_W-1] == 1'b1) begin
        dest = in_flit[i][ID_W+2:3];
        if (!ejected && dest == cthulhu) begin
          buffit_d = in_flit[i];
          ejected  = 1'b1;
        end else begin
          {has_prod, prod} = productive(dest, cthulhu);
          sel = first_free(taken);
          if (has_prod && !taken[prod]) sel = prod;
          out_d[sel] = in_flit[i];
          taken[sel] = 1'b1;
        end
      end
    end
    inject_d = ~&taken;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) out_q[p] <= '0;
      buffit_q <= '0;
      inject_q <= 1'b0;
    end else begin
      for (int p = 0; p < 4; p++) out_q[p] <= out_d[p];
      buffit_q <= buffit_d;
      inject_q <= inject_d;
    end
  end

  assign nad    = out_q[P_N];
  assign ead    = out_q[P_E];
  assign sad    = out_q[P_S];
  assign wad    = out_q[P_W];
  assign buffit = buffit_q;
  assign inject = inject_q;

endmodule

// File: tb/tb_redirect.sv
// Scoreboard bench for redirect: the driver queues expected outputs and the monitor checks them one cycle later.
module tb_redirect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cthulhu = '0;
  logic [10:0] northad = '0, southad = '0, eastad = '0, westad = '0;
  logic [10:0] nad, sad, ead, wad, buffit;
  logic        inject;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [10:0] n, s, e, w, b;
    logic        inj;
  } exp_t;

  exp_t q[$];

  redirect dut (
    .clk(clk), .rst(rst), .cthulhu(cthulhu),
    .northad(northad), .southad(southad), .eastad(eastad), .westad(westad),
    .nad(nad), .sad(sad), .ead(ead), .wad(wad),
    .buffit(buffit), .inject(inject)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [10:0] n, logic [10:0] s, logic [10:0] e,
                              logic [10:0] w, logic [10:0] b, logic inj);
    exp_t r;
    r.n = n; r.s = s; r.e = e; r.w = w; r.b = b; r.inj = inj;
    return r;
  endfunction

  // Reference: walk the inputs in priority order and hand out ports from a free list.
  function automatic exp_t model(bit r, logic [2:0] id, logic [10:0] fn,
                                 logic [10:0] fe, logic [10:0] fs, logic [10:0] fw);
    logic [10:0] fl [4];
    logic [10:0] port [4];
    bit          used [4];
    bit          ej;
    int          placed, want, x, y, dx, dy;
    exp_t        res;
    res = mk('0, '0, '0, '0, '0, 1'b0);
    if (r) return res;
    fl[0] = fn; fl[1] = fe; fl[2] = fs; fl[3] = fw;
    for (int p = 0; p < 4; p++) begin port[p] = '0; used[p] = 0; end
    ej = 0; placed = 0;
    x = int'(id[1:0]); y = int'(id[2]);
    for (int i = 0; i < 4; i++) begin
      if (fl[i][10] !== 1'b1) continue;
      if (!ej && fl[i][5:3] == id) begin
        res.b = fl[i]; ej = 1;
        continue;
      end
      dx = int'(fl[i][4:3]); dy = int'(fl[i][5]);
      want = -1;
      if (dx > x) want = 1;
      else if (dx < x) want = 3;
      else if (dy > y) want = 2;
      else if (dy < y) want = 0;
      if (want < 0 || used[want]) begin
        want = -1;
        for (int p = 0; p < 4; p++) if (want < 0 && !used[p]) want = p;
      end
      port[want] = fl[i]; used[want] = 1; placed++;
    end
    res.n = port[0]; res.e = port[1]; res.s = port[2]; res.w = port[3];
    res.inj = (placed < 4);
    return res;
  endfunction

  task automatic apply(bit r, logic [2:0] id, logic [10:0] fn, logic [10:0] fe,
                       logic [10:0] fs, logic [10:0] fw);
    @(negedge clk);
    rst = r; cthulhu = id;
    northad = fn; eastad = fe; southad = fs; westad = fw;
  endtask

  task automatic drive(bit r, logic [2:0] id, logic [10:0] fn, logic [10:0] fe,
                       logic [10:0] fs, logic [10:0] fw);
    apply(r, id, fn, fe, fs, fw);
    q.push_back(model(r, id, fn, fe, fs, fw));
    @(posedge clk);
  endtask

  task automatic drive_exp(bit r, logic [2:0] id, logic [10:0] fn, logic [10:0] fe,
                           logic [10:0] fs, logic [10:0] fw, exp_t ex);
    apply(r, id, fn, fe, fs, fw);
    q.push_back(ex);
    @(posedge clk);
  endtask

  task automatic chk(string name, logic [10:0] act, logic [10:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, one edge after their inputs.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        ex = q.pop_front();
        chk("nad", nad, ex.n);
        chk("sad", sad, ex.s);
        chk("ead", ead, ex.e);
        chk("wad", wad, ex.w);
        chk("buffit", buffit, ex.b);
        chk("inject", {10'b0, inject}, {10'b0, ex.inj});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] f [4];
    // Reset with garbage on the inputs, then release with idle inputs.
    drive_exp(1, 3'd0, 11'h7FF, 11'h5AA, 11'h4F0, 11'h7C3, mk('0, '0, '0, '0, '0, 1'b0));
    drive_exp(1, 3'd5, 11'h400, 11'h401, 11'h402, 11'h403, mk('0, '0, '0, '0, '0, 1'b0));
    drive_exp(0, 3'd0, '0, '0, '0, '0, mk('0, '0, '0, '0, '0, 1'b1));
    // Single flit routed east.
    drive_exp(0, 3'd0, 11'b10000011000, '0, '0, '0,
              mk('0, '0, 11'b10000011000, '0, '0, 1'b1));
    // Two local flits: north ejects, east deflects to the first free port.
    drive_exp(0, 3'd5, 11'b10000101000, 11'b10000101001, '0, '0,
              mk(11'b10000101001, '0, '0, '0, 11'b10000101000, 1'b1));
    // Same column, lower row: go north.
    drive_exp(0, 3'd5, 11'b10000001000, '0, '0, '0,
              mk(11'b10000001000, '0, '0, '0, '0, 1'b1));
    // Four flits all wanting east.
    drive_exp(0, 3'd0, 11'b10000011000, 11'b10000011001, 11'b10000011010, 11'b10000011011,
              mk(11'b10000011001, 11'b10000011010, 11'b10000011000, 11'b10000011011, '0, 1'b0));
    // Reset mid-stream with four valid flits present, then resume.
    drive(0, 3'd2, 11'b10101000001, 11'b11110111010, 11'b10011101011, 11'b10000010100);
    drive(1, 3'd2, 11'b10101000001, 11'b11110111010, 11'b10011101011, 11'b10000010100);
    drive(0, 3'd2, 11'b10101000001, 11'b11110111010, 11'b10011101011, 11'b10000010100);
    // Empty-flagged inputs with junk in other bits are ignored.
    drive_exp(0, 3'd3, 11'b01111111111, 11'b00000011000, '0, 11'b01010101010,
              mk('0, '0, '0, '0, '0, 1'b1));
    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        f[i] = 11'($urandom);
        f[i][10] = ($urandom_range(0, 9) < 7);
      end
      drive(($urandom_range(0, 39) == 0), 3'($urandom), f[0], f[1], f[2], f[3]);
    end
    drive(0, 3'd0, '0, '0, '0, '0);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/redirect.md
Name: redirect

Overview:
- Single-cycle deflection routing core of a bufferless mesh router node, with registered outputs.
- Accepts up to four 11-bit flits per cycle, one per cardinal input (north, south, east, west).
- Ejects at most one flit addressed to this node. Steers every other valid flit to exactly one output port, deflecting when the productive port is taken.
- Reports whether an output slot is free for local injection.
- Sits between the link input registers and the link output drivers of each of 8 nodes, arranged as a 4-column x 2-row mesh.

Parameters:
- FLIT_W, 11, flit width in bits.
- ID_W, 3, node/destination ID width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cthulhu  input  3  this node's ID: x = cthulhu[1:0], y = cthulhu[2].
- northad  input  11  flit arriving from north.
- southad  input  11  flit arriving from south.
- eastad  input  11  flit arriving from east.
- westad  input  11  flit arriving from west.
- nad  output  11  flit leaving north.
- sad  output  11  flit leaving south.
- ead  output  11  flit leaving east.
- wad  output  11  flit leaving west.
- buffit  output  11  flit ejected to the local node.
- inject  output  1  high when at least one of nad/sad/ead/wad carries no flit this cycle.

Behaviour:
- Flit format:
  - [10] valid.
  - [9:6] payload.
  - [5:3] destination ID: dx = [4:3], dy = [5].
  - [2:0] source ID, passed through unchanged.
- A flit with bit 10 = 0 is empty; any X/Z in bit 10 also counts as empty. Empty output value = 11'b0.
- Outputs are registered: latency is exactly 1 clock. Inputs sampled at edge k appear on outputs after edge k; no handshake.
- Reset: when rst=1 at a clock edge, nad/sad/ead/wad/buffit <= 0 and inject <= 0. Reset takes priority over any inputs present that cycle, and in-flight flits are discarded.
- Input priority order (fixed): north, east, south, west. Higher-priority flits are allocated first.
- Ejection:
  - The highest-priority valid flit whose destination == cthulhu goes to buffit.
  - Other local-destined flits that cycle are deflected like normal flits.
  - If no flit is ejected, buffit = 0.
- Productive direction (XY routing):
  - dx > x: east; dx < x: west.
  - Otherwise dy > y: south; dy < y: north.
- Allocation, in priority order, for each non-ejected valid flit:
  - Take its productive port if still free.
  - Otherwise take the first free port in order N, E, S, W.
  - A local-destined flit that lost ejection uses that first-free order directly.
- Four inputs and four outputs guarantee every valid flit gets a port; no flit is ever dropped.
- Each output carries at most one flit. Unused outputs = 0.
- inject = 1 iff fewer than 4 flits were placed on nad/sad/ead/wad that cycle. Registered with the outputs.
- Mesh-edge ports are always driven; edge wrap/loopback is handled outside this block.
- Combinational allocation must complete in one cycle; no internal state besides the output registers.

Test Plan:
- Reset, then hold rst=1 with any inputs -> after edge all outputs 0, inject=0. Release with all inputs 0 -> next edge inject=1, all flit outputs 0.
- cthulhu=0, northad=11'b10000011000 (dest 3), others 0 -> next cycle ead=11'b10000011000, nad=sad=wad=buffit=0, inject=1.
- cthulhu=5, northad=11'b10000101000 and eastad=11'b10000101001 (both dest 5) -> buffit=11'b10000101000, nad=11'b10000101001, ead=sad=wad=0, inject=1.
- cthulhu=5, northad=11'b10000001000 (dest 1: same x, y=0) -> nad=11'b10000001000.
- cthulhu=0, all four inputs valid with dest 3 (N=11'b10000011000, E=..001, S=..010, W=..011):
  - ead=N flit, nad=E flit, sad=S flit, wad=W flit.
  - buffit=0, inject=0.
- Assert rst mid-stream while four valid flits are in flight -> next edge all outputs 0, inject=0. Traffic resumes normally the cycle after rst deasserts.
